// File: rtl/multiciclo_top.sv
// Multicycle MIPS-subset core (LW, SW, BEQ, R-type ADD/SUB/AND/OR/SLT) with internal imem/dmem/regs.
// Optional feature: define MULTICICLO_ADDI_EN to add ADDI (opcode 0x08).
module multiciclo_top #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int RESET_PC   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [31:0]                   instruction,
    output logic [31:0]                   write_data,
    output logic [3:0]                    operation,
    output logic                          Zero,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic [2:0]                    state,
    output logic                          instr_done,
    output logic                          halted
);

    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);
    localparam logic [PW:0] IMEM_LIMIT = (PW+1)'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] regs [32];

    state_t        state_r, state_nx_s;
    logic [PW-1:0] pc_r;
    logic [31:0]   ir_r, a_r, b_r, imm_r, alu_out_r, mdr_r, write_data_r;
    logic [3:0]    operation_r;
    logic          zero_r, instr_done_r, halted_r, done_nx_s;

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, wr_sel_s;
    logic [31:0] imm_ext_s, alu_b_s, alu_res_s;
    logic [3:0]  alu_op_s;
    logic        is_lw_s, is_sw_s, is_beq_s, is_r_s, is_addi_s, funct_ok_s, valid_s;
    logic [DW-1:0] daddr_s;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign opcode_s  = ir_r[31:26];
    assign rs_s      = ir_r[25:21];
    assign rt_s      = ir_r[20:16];
    assign rd_s      = ir_r[15:11];
    assign funct_s   = ir_r[5:0];
    assign imm_ext_s = {{16{ir_r[15]}}, ir_r[15:0]};
    assign daddr_s   = alu_out_r[DW-1:0];

`ifdef MULTICICLO_ADDI_EN
    assign is_addi_s = (opcode_s == 6'h08);
`else
    assign is_addi_s = 1'b0;
`endif

    // Instruction decode and ALU control; IR is stable from DECODE until retirement
    always_comb begin
        is_lw_s    = (opcode_s == 6'h23);
        is_sw_s    = (opcode_s == 6'h2B);
        is_beq_s   = (opcode_s == 6'h04);
        is_r_s     = (opcode_s == 6'h00);
        funct_ok_s = 1'b1;
        alu_op_s   = 4'b0010;
        if (is_r_s) begin
            case (funct_s)
                6'h20:   alu_op_s = 4'b0010;
                6'h22:   alu_op_s = 4'b0110;
                6'h24:   alu_op_s = 4'b0000;
                6'h25:   alu_op_s = 4'b0001;
                6'h2A:   alu_op_s = 4'b0111;
                default: funct_ok_s = 1'b0;
            endcase
        end else if (is_beq_s) begin
            alu_op_s = 4'b0110;
        end else begin
            alu_op_s = 4'b0010;
        end
        valid_s   = is_lw_s | is_sw_s | is_beq_s | (is_r_s & funct_ok_s) | is_addi_s;
        alu_b_s   = (is_r_s | is_beq_s) ? b_r : imm_r;
        alu_res_s = alu_f(alu_op_s, a_r, alu_b_s);
        wr_sel_s  = is_r_s ? rd_s : rt_s;
    end

    // Next-state logic; done_nx_s marks entry into an instruction's final cycle
    always_comb begin
        state_nx_s = state_r;
        done_nx_s  = 1'b0;
        case (state_r)
            FETCH: begin
                if ({1'b0, pc_r} >= IMEM_LIMIT) begin
                    state_nx_s = HALT;
                end else begin
                    state_nx_s = DECODE;
                end
            end
            DECODE: begin
                if (valid_s) begin
                    state_nx_s = EXEC;
                    done_nx_s  = is_beq_s;
                end else begin
                    state_nx_s = HALT;
                end
            end
            EXEC: begin
                if (is_lw_s || is_sw_s) begin
                    state_nx_s = MEM;
                    done_nx_s  = is_sw_s;
                end else if (is_beq_s) begin
                    state_nx_s = FETCH;
                end else begin
                    state_nx_s = WB;
                    done_nx_s  = 1'b1;
                end
            end
            MEM: begin
                if (is_lw_s) begin
                    state_nx_s = WB;
                    done_nx_s  = 1'b1;
                end else begin
                    state_nx_s = FETCH;
                end
            end
            WB:      state_nx_s = FETCH;
            HALT:    state_nx_s = HALT;
            default: state_nx_s = HALT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath registers and register file; reset takes priority over any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC[PW-1:0];
            ir_r         <= 32'd0;
            a_r          <= 32'd0;
            b_r          <= 32'd0;
            imm_r        <= 32'd0;
            alu_out_r    <= 32'd0;
            mdr_r        <= 32'd0;
            write_data_r <= 32'd0;
            operation_r  <= 4'b0010;
            zero_r       <= 1'b0;
            instr_done_r <= 1'b0;
            halted_r     <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            instr_done_r <= done_nx_s;
            halted_r     <= (state_nx_s == HALT);
            case (state_r)
                FETCH: begin
                    if (state_nx_s == DECODE) begin
                        ir_r <= imem[pc_r];
                        pc_r <= pc_r + PW'(1);
                    end
                end
                DECODE: begin
                    a_r   <= (rs_s == 5'd0) ? 32'd0 : regs[rs_s];
                    b_r   <= (rt_s == 5'd0) ? 32'd0 : regs[rt_s];
                    imm_r <= imm_ext_s;
                end
                EXEC: begin
                    operation_r <= alu_op_s;
                    zero_r      <= (alu_res_s == 32'd0);
                    alu_out_r   <= alu_res_s;
                    // pc already points past the branch, so the offset is added to pc+1
                    if (is_beq_s && (alu_res_s == 32'd0)) begin
                        pc_r <= pc_r + imm_r[PW-1:0];
                    end
                end
                MEM: begin
                    if (is_lw_s) begin
                        mdr_r <= dmem[daddr_s];
                    end
                    if (is_sw_s) begin
                        write_data_r <= b_r;
                    end
                end
                WB: begin
                    if (is_lw_s) begin
                        write_data_r <= mdr_r;
                        if (wr_sel_s != 5'd0) begin
                            regs[wr_sel_s] <= mdr_r;
                        end
                    end else begin
                        write_data_r <= alu_out_r;
                        if (wr_sel_s != 5'd0) begin
                            regs[wr_sel_s] <= alu_out_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Data memory store port; not reset, and a reset cycle suppresses the store
    always_ff @(posedge clk) begin
        if (!rst && (state_r == MEM) && is_sw_s) begin
            dmem[daddr_s] <= b_r;
        end
    end

    assign instruction = ir_r;
    assign write_data  = write_data_r;
    assign operation   = operation_r;
    assign Zero        = zero_r;
    assign pc          = pc_r;
    assign state       = state_r;
    assign instr_done  = instr_done_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_multiciclo_top.sv
// Directed self-checking bench for multiciclo_top; honours MULTICICLO_ADDI_EN when defined.
module tb_multiciclo_top;

    logic        clk;
    logic        rst;
    logic [31:0] instruction, write_data;
    logic [3:0]  operation;
    logic        Zero;
    logic [5:0]  pc;
    logic [2:0]  state;
    logic        instr_done, halted;

    int n_total;
    int n_pass;

    multiciclo_top dut (
        .clk(clk), .rst(rst), .instruction(instruction), .write_data(write_data),
        .operation(operation), .Zero(Zero), .pc(pc), .state(state),
        .instr_done(instr_done), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] funct);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        for (int i = 0; i < 64; i++) begin
            dut.imem[i] = 32'hFC00_0000;
            dut.dmem[i] = 32'd0;
        end
        dut.imem[0]  = enc_i(6'h23, 0, 8, 5);            // LW  $8,5($0)
        dut.imem[1]  = enc_r(17, 18, 9, 6'h20);          // ADD $9,$17,$18
        dut.imem[2]  = enc_r(17, 18, 10, 6'h22);         // SUB $10,$17,$18
        dut.imem[3]  = enc_i(6'h2B, 10, 9, 8);           // SW  $9,8($10)
        dut.imem[4]  = enc_r(17, 18, 0, 6'h20);          // ADD $0,$17,$18
        dut.imem[5]  = enc_i(6'h04, 8, 11, 4);           // BEQ $8,$11,+4 taken
        dut.imem[10] = enc_i(6'h04, 8, 17, 4);           // BEQ $8,$17,+4 not taken
        dut.imem[11] = enc_r(17, 19, 12, 6'h24);         // AND
        dut.imem[12] = enc_r(17, 18, 13, 6'h25);         // OR
        dut.imem[13] = enc_r(20, 17, 14, 6'h2A);         // SLT -1 < 4
        dut.imem[14] = enc_r(17, 20, 15, 6'h2A);         // SLT 4 < -1
        dut.imem[15] = enc_r(20, 21, 16, 6'h20);         // ADD wrap
        dut.imem[16] = enc_i(6'h08, 0, 22, -1);          // ADDI $22,$0,-1
        dut.dmem[5]  = 32'h0000_000A;
        dut.dmem[10] = 32'hDEAD_BEEF;

        tick(1);
        dut.regs[5] = 32'h1234_5678;
        tick(2);
        chk("rst_pc", {26'd0, pc}, 32'd0);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_ir", instruction, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_op", {28'd0, operation}, 32'd2);
        chk("rst_zero", {31'd0, Zero}, 32'd0);
        chk("rst_done", {31'd0, instr_done}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_regs5", dut.regs[5], 32'd0);

        rst = 1'b0;
        dut.regs[11] = 32'h0000_000A;
        dut.regs[17] = 32'd4;
        dut.regs[18] = 32'd2;
        dut.regs[19] = 32'h0000_000C;
        dut.regs[20] = 32'hFFFF_FFFF;
        dut.regs[21] = 32'd1;

        tick(4);
        chk("lw_wb_state", {29'd0, state}, 32'd4);
        chk("lw_wb_done", {31'd0, instr_done}, 32'd1);
        chk("lw_ir", instruction, 32'h8C08_0005);
        tick(1);
        chk("lw_reg8", dut.regs[8], 32'h0000_000A);
        chk("lw_wdata", write_data, 32'h0000_000A);
        chk("lw_done_low", {31'd0, instr_done}, 32'd0);
        chk("lw_pc", {26'd0, pc}, 32'd1);

        tick(3);
        chk("add_done", {31'd0, instr_done}, 32'd1);
        chk("add_op", {28'd0, operation}, 32'd2);
        tick(1);
        chk("add_reg9", dut.regs[9], 32'd6);
        chk("add_wdata", write_data, 32'd6);

        tick(4);
        chk("sub_reg10", dut.regs[10], 32'd2);
        chk("sub_op", {28'd0, operation}, 32'd6);
        chk("sub_zero", {31'd0, Zero}, 32'd0);

        tick(3);
        chk("sw_mem_state", {29'd0, state}, 32'd3);
        chk("sw_done", {31'd0, instr_done}, 32'd1);
        tick(1);
        chk("sw_dmem10", dut.dmem[10], 32'd6);
        chk("sw_wdata", write_data, 32'd6);
        chk("sw_pc", {26'd0, pc}, 32'd4);

        dut.regs[17] = 32'd5;
        tick(4);
        chk("add_r0", dut.regs[0], 32'd0);
        chk("add_r0_wdata", write_data, 32'd7);

        dut.regs[17] = 32'd4;
        tick(2);
        chk("beq_done", {31'd0, instr_done}, 32'd1);
        tick(1);
        chk("beq_taken_pc", {26'd0, pc}, 32'd10);
        chk("beq_zero", {31'd0, Zero}, 32'd1);
        chk("beq_op", {28'd0, operation}, 32'd6);
        chk("beq_state", {29'd0, state}, 32'd0);

        tick(3);
        chk("beq_nt_pc", {26'd0, pc}, 32'd11);
        chk("beq_nt_zero", {31'd0, Zero}, 32'd0);

        tick(4);
        chk("and_reg12", dut.regs[12], 32'd4);
        chk("and_op", {28'd0, operation}, 32'd0);
        tick(4);
        chk("or_reg13", dut.regs[13], 32'd6);
        chk("or_op", {28'd0, operation}, 32'd1);
        tick(4);
        chk("slt_neg", dut.regs[14], 32'd1);
        chk("slt_op", {28'd0, operation}, 32'd7);
        tick(4);
        chk("slt_pos", dut.regs[15], 32'd0);
        tick(4);
        chk("add_wrap", dut.regs[16], 32'd0);
        chk("add_wrap_zero", {31'd0, Zero}, 32'd1);
        chk("pc16", {26'd0, pc}, 32'd16);

`ifdef MULTICICLO_ADDI_EN
        tick(4);
        chk("addi_reg22", dut.regs[22], 32'hFFFF_FFFF);
        chk("addi_op", {28'd0, operation}, 32'd2);
        tick(2);
        chk("halt_state", {29'd0, state}, 32'd7);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", {26'd0, pc}, 32'd18);
        tick(3);
        chk("halt_hold_pc", {26'd0, pc}, 32'd18);
`else
        tick(2);
        chk("halt_state", {29'd0, state}, 32'd7);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", {26'd0, pc}, 32'd17);
        chk("halt_reg22", dut.regs[22], 32'd0);
        tick(3);
        chk("halt_hold_pc", {26'd0, pc}, 32'd17);
`endif
        chk("halt_no_done", {31'd0, instr_done}, 32'd0);
        chk("halt_hold_state", {29'd0, state}, 32'd7);

        rst = 1'b1;
        tick(1);
        chk("rst_halt_state", {29'd0, state}, 32'd0);
        chk("rst_halt_flag", {31'd0, halted}, 32'd0);
        chk("rst_halt_pc", {26'd0, pc}, 32'd0);
        chk("rst_regs9", dut.regs[9], 32'd0);
        tick(1);
        rst = 1'b0;
        tick(3);
        chk("lw2_mem_state", {29'd0, state}, 32'd3);
        rst = 1'b1;
        tick(1);
        chk("lw_abort_reg8", dut.regs[8], 32'd0);
        chk("lw_abort_pc", {26'd0, pc}, 32'd0);
        chk("lw_abort_state", {29'd0, state}, 32'd0);

        dut.imem[0] = enc_i(6'h2B, 0, 17, 0);            // SW $17,0($0)
        dut.dmem[0] = 32'h0000_0077;
        tick(1);
        rst = 1'b0;
        dut.regs[17] = 32'h0000_0055;
        tick(3);
        chk("sw2_mem_state", {29'd0, state}, 32'd3);
        rst = 1'b1;
        tick(1);
        chk("sw_abort_dmem0", dut.dmem[0], 32'h0000_0077);
        chk("sw_abort_state", {29'd0, state}, 32'd0);
        chk("sw_abort_wdata", write_data, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
